// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the data-memory bus arbiter.
// Holds the FSM state enum, master indices and stats width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_ARB,
        S_LOCK1,
        S_COOL
    } arb_state_e;

    localparam int M_CPU  = 0;
    localparam int M_LDR  = 1;
    localparam int STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(
        input logic [STAT_W-1:0] v
    );
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Two-master data-memory bus plus the DataMem side.
// slave = arbiter view, master = requester/memory view.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_rd;
    logic              m0_wr;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_rvalid;

    logic              m1_req;
    logic              m1_rd;
    logic              m1_wr;
    logic              m1_lock;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_rvalid;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_rd, m0_wr, m0_addr, m0_wdata,
        input  m1_req, m1_rd, m1_wr, m1_lock,
        input  m1_addr, m1_wdata, mem_rdata,
        output m0_gnt, m0_rdata, m0_rvalid,
        output m1_gnt, m1_rdata, m1_rvalid,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output m0_req, m0_rd, m0_wr, m0_addr, m0_wdata,
        output m1_req, m1_rd, m1_wr, m1_lock,
        output m1_addr, m1_wdata, mem_rdata,
        input  m0_gnt, m0_rdata, m0_rvalid,
        input  m1_gnt, m1_rdata, m1_rvalid,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_bus_arbiter_stats.sv
// Saturating grant / starvation counters for the arbiter.
// Only built when MEM_BUS_ARB_STATS_EN is defined.
`ifdef MEM_BUS_ARB_STATS_EN
module arb_stats
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              gnt0_i,
    input  logic              gnt1_i,
    input  logic              forced_i,
    output logic [STAT_W-1:0] gnt0_o,
    output logic [STAT_W-1:0] gnt1_o,
    output logic [STAT_W-1:0] starve_o
);
    logic [STAT_W-1:0] cnt0_q, cnt0_d;
    logic [STAT_W-1:0] cnt1_q, cnt1_d;
    logic [STAT_W-1:0] cnts_q, cnts_d;

    always_comb begin
        cnt0_d = gnt0_i   ? sat_inc(cnt0_q) : cnt0_q;
        cnt1_d = gnt1_i   ? sat_inc(cnt1_q) : cnt1_q;
        cnts_d = forced_i ? sat_inc(cnts_q) : cnts_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
            cnts_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
            cnts_q <= cnts_d;
        end
    end

    assign gnt0_o   = cnt0_q;
    assign gnt1_o   = cnt1_q;
    assign starve_o = cnts_q;
endmodule
`endif

// File: rtl/mem_bus_arbiter.sv
// CPU / loader arbiter for the DataMem port: fixed CPU priority,
// starvation override and locked loader bursts. Stats: MEM_BUS_ARB_STATS_EN.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8,
    parameter int MAX_BURST    = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_arbiter_if.slave  bus
`ifdef MEM_BUS_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_gnt0,
    output logic [STAT_W-1:0] stat_gnt1,
    output logic [STAT_W-1:0] stat_starve
`endif
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);

    arb_state_e        state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic              gnt0, gnt1;
    logic              rhit0, rhit1;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              rvalid0_q, rvalid1_q;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;
    logic              rd_mux, wr_mux;

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        unique case (state_q)
            S_ARB: begin
                if (bus.m1_req && starve_q == STARVE_MAX) gnt1 = 1'b1;
                else if (bus.m0_req)                      gnt0 = 1'b1;
                else if (bus.m1_req)                      gnt1 = 1'b1;
                if (gnt1 && bus.m1_lock) begin
                    if (MAX_BURST == 1) begin
                        state_d = S_COOL;
                        burst_d = '0;
                    end else begin
                        state_d = S_LOCK1;
                        burst_d = BW'(1);
                    end
                end
            end
            S_LOCK1: begin
                // Lock exit cycle grants nobody.
                if (bus.m1_req && bus.m1_lock) begin
                    gnt1 = 1'b1;
                    if (burst_q + BW'(1) == BURST_MAX) begin
                        state_d = S_COOL;
                        burst_d = '0;
                    end else begin
                        burst_d = burst_q + BW'(1);
                    end
                end else begin
                    state_d = S_ARB;
                    burst_d = '0;
                end
            end
            S_COOL: begin
                gnt0    = bus.m0_req;
                state_d = S_ARB;
            end
            default: begin
                state_d = S_ARB;
                burst_d = '0;
            end
        endcase
        if (reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!bus.m1_req || gnt1)
            starve_d = '0;
        else if (starve_q != STARVE_MAX)
            starve_d = starve_q + SW'(1);
    end

    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        rd_mux    = 1'b0;
        wr_mux    = 1'b0;
        if (gnt0) begin
            addr_mux  = bus.m0_addr;
            wdata_mux = bus.m0_wdata;
            rd_mux    = bus.m0_rd;
            wr_mux    = bus.m0_wr;
        end else if (gnt1) begin
            addr_mux  = bus.m1_addr;
            wdata_mux = bus.m1_wdata;
            rd_mux    = bus.m1_rd;
            wr_mux    = bus.m1_wr;
        end
    end

    assign rhit0 = gnt0 & bus.m0_rd & ~bus.m0_wr;
    assign rhit1 = gnt1 & bus.m1_rd & ~bus.m1_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_ARB;
            starve_q  <= '0;
            burst_q   <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            burst_q   <= burst_d;
            rvalid0_q <= rhit0;
            rvalid1_q <= rhit1;
            if (rhit0) rdata0_q <= bus.mem_rdata;
            if (rhit1) rdata1_q <= bus.mem_rdata;
        end
    end

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;
    assign bus.m0_rvalid = rvalid0_q;
    assign bus.m1_rvalid = rvalid1_q;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;
    assign bus.mem_write = wr_mux;
    assign bus.mem_read  = rd_mux & ~wr_mux;

`ifdef MEM_BUS_ARB_STATS_EN
    logic forced;
    assign forced = gnt1 && state_q == S_ARB && starve_q == STARVE_MAX;

    arb_stats u_stats (
        .clk      (clk),
        .reset    (reset),
        .gnt0_i   (gnt0),
        .gnt1_i   (gnt1),
        .forced_i (forced),
        .gnt0_o   (stat_gnt0),
        .gnt1_o   (stat_gnt1),
        .starve_o (stat_starve)
    );
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized + directed bench for mem_bus_arbiter against a
// cycle-level behavioural model of the arbitration rules.
module tb_mem_bus_arbiter;
    localparam int STARVE_LIMIT = 8;
    localparam int MAX_BURST    = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic [31:0] ram [64];

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_BUS_ARB_STATS_EN
    logic [15:0] stat_gnt0, stat_gnt1, stat_starve;
`endif

    mem_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32),
        .STARVE_LIMIT(STARVE_LIMIT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MEM_BUS_ARB_STATS_EN
        ,
        .stat_gnt0   (stat_gnt0),
        .stat_gnt1   (stat_gnt1),
        .stat_starve (stat_starve)
`endif
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = ram[bus.mem_addr[5:0]];

    always @(posedge clk)
        if (bus.mem_write) ram[bus.mem_addr[5:0]] <= bus.mem_wdata;

    // Reference model: mode 0 = open, 1 = loader owns bus, 2 = cool-down
    int          md_mode, md_starve, md_burst;
    bit          md_rv0, md_rv1;
    logic [31:0] md_rd0, md_rd1;

    function automatic void mdl_grant(output bit g0, output bit g1);
        g0 = 0;
        g1 = 0;
        if (reset) return;
        if (md_mode == 0) begin
            if (bus.m1_req && md_starve == STARVE_LIMIT) g1 = 1;
            else if (bus.m0_req) g0 = 1;
            else if (bus.m1_req) g1 = 1;
        end else if (md_mode == 1) begin
            g1 = bus.m1_req && bus.m1_lock;
        end else begin
            g0 = bus.m0_req;
        end
    endfunction

    function automatic void mdl_update(input bit g0, input bit g1,
                                       input bit rd, input logic [31:0] v);
        if (reset) begin
            md_mode = 0; md_starve = 0; md_burst = 0;
            md_rv0 = 0; md_rv1 = 0; md_rd0 = 0; md_rd1 = 0;
            return;
        end
        md_rv0 = g0 && rd;
        md_rv1 = g1 && rd;
        if (md_rv0) md_rd0 = v;
        if (md_rv1) md_rd1 = v;
        if (!bus.m1_req || g1) md_starve = 0;
        else if (md_starve < STARVE_LIMIT) md_starve++;
        if (md_mode == 0) begin
            if (g1 && bus.m1_lock) begin
                md_burst = 1;
                md_mode = (md_burst >= MAX_BURST) ? 2 : 1;
            end
        end else if (md_mode == 1) begin
            if (g1) begin
                md_burst++;
                if (md_burst >= MAX_BURST) md_mode = 2;
            end else begin
                md_mode = 0;
            end
        end else begin
            md_mode = 0;
        end
    endfunction

    task automatic run_cycle(output bit e0, output bit e1,
                             output logic d0, output logic d1,
                             output logic dmr, output logic dmw);
        logic [31:0] ea, ew, eram;
        bit er, ewr;
        @(negedge clk);
        mdl_grant(e0, e1);
        ea = 0; ew = 0; er = 0; ewr = 0;
        if (e0) begin
            ea = bus.m0_addr; ew = bus.m0_wdata;
            ewr = bus.m0_wr; er = bus.m0_rd && !bus.m0_wr;
        end else if (e1) begin
            ea = bus.m1_addr; ew = bus.m1_wdata;
            ewr = bus.m1_wr; er = bus.m1_rd && !bus.m1_wr;
        end
        eram = ram[ea[5:0]];
        d0 = bus.m0_gnt; d1 = bus.m1_gnt;
        dmr = bus.mem_read; dmw = bus.mem_write;
        total++;
        if (bus.m0_gnt !== e0) begin
            bad++;
            $display("FAIL m0_gnt got=%b want=%b t=%0t", bus.m0_gnt, e0, $time);
        end
        total++;
        if (bus.m1_gnt !== e1) begin
            bad++;
            $display("FAIL m1_gnt got=%b want=%b t=%0t", bus.m1_gnt, e1, $time);
        end
        total++;
        if (bus.mem_read !== er) begin
            bad++;
            $display("FAIL mem_read got=%b want=%b t=%0t", bus.mem_read, er, $time);
        end
        total++;
        if (bus.mem_write !== ewr) begin
            bad++;
            $display("FAIL mem_write got=%b want=%b t=%0t", bus.mem_write, ewr, $time);
        end
        total++;
        if (bus.mem_addr !== ea) begin
            bad++;
            $display("FAIL mem_addr got=%h want=%h t=%0t", bus.mem_addr, ea, $time);
        end
        total++;
        if (bus.mem_wdata !== ew) begin
            bad++;
            $display("FAIL mem_wdata got=%h want=%h t=%0t", bus.mem_wdata, ew, $time);
        end
        total++;
        if (bus.m0_rvalid !== md_rv0 || bus.m1_rvalid !== md_rv1) begin
            bad++;
            $display("FAIL rvalid got=%b%b want=%b%b t=%0t",
                     bus.m0_rvalid, bus.m1_rvalid, md_rv0, md_rv1, $time);
        end
        total++;
        if (bus.m0_rdata !== md_rd0 || bus.m1_rdata !== md_rd1) begin
            bad++;
            $display("FAIL rdata got=%h/%h want=%h/%h t=%0t",
                     bus.m0_rdata, bus.m1_rdata, md_rd0, md_rd1, $time);
        end
        @(posedge clk);
        mdl_update(e0, e1, er, eram);
        #1;
    endtask

    task automatic idle();
        bus.m0_req = 0; bus.m0_rd = 0; bus.m0_wr = 0;
        bus.m0_addr = 0; bus.m0_wdata = 0;
        bus.m1_req = 0; bus.m1_rd = 0; bus.m1_wr = 0; bus.m1_lock = 0;
        bus.m1_addr = 0; bus.m1_wdata = 0;
    endtask

    task automatic test_reset();
        bit e0, e1;
        logic d0, d1, mr, mw;
        idle();
        bus.m0_req = 1; bus.m0_rd = 1;
        bus.m1_req = 1; bus.m1_rd = 1;
        reset = 1;
        repeat (2) run_cycle(e0, e1, d0, d1, mr, mw);
        total++;
        if (d0 !== 1'b0 || d1 !== 1'b0 || mr !== 1'b0) begin
            bad++;
            $display("FAIL reset_gnt got=%b%b%b want=000", d0, d1, mr);
        end
        reset = 0;
        idle();
        run_cycle(e0, e1, d0, d1, mr, mw);
    endtask

    task automatic test_both_read();
        bit e0, e1;
        logic d0, d1, mr, mw;
        logic [31:0] want;
        want = ram[6'h10];
        bus.m0_req = 1; bus.m0_rd = 1; bus.m0_addr = 32'h10;
        bus.m1_req = 1; bus.m1_rd = 1; bus.m1_addr = 32'h20;
        run_cycle(e0, e1, d0, d1, mr, mw);
        total++;
        if (d0 !== 1'b1 || d1 !== 1'b0 || mr !== 1'b1) begin
            bad++;
            $display("FAIL both_read gnt got=%b%b rd=%b want=101", d0, d1, mr);
        end
        total++;
        if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== want) begin
            bad++;
            $display("FAIL both_read data got=%b/%h want=1/%h",
                     bus.m0_rvalid, bus.m0_rdata, want);
        end
        idle();
        run_cycle(e0, e1, d0, d1, mr, mw);
    endtask

    task automatic test_starve();
        bit e0, e1;
        logic d0, d1, mr, mw;
        int first;
        logic g10;
        first = 0;
        g10 = 0;
        bus.m0_req = 1; bus.m0_rd = 1; bus.m0_addr = 1;
        bus.m1_req = 1; bus.m1_rd = 1; bus.m1_addr = 32'h20;
        for (int c = 1; c <= 12; c++) begin
            run_cycle(e0, e1, d0, d1, mr, mw);
            if (d1 && first == 0) first = c;
            if (c == 10) g10 = d0;
            if (e0) bus.m0_addr = bus.m0_addr + 1;
            if (e1) bus.m1_req = 0;
        end
        total++;
        if (first !== STARVE_LIMIT + 1) begin
            bad++;
            $display("FAIL starve_cycle got=%0d want=%0d", first, STARVE_LIMIT + 1);
        end
        total++;
        if (g10 !== 1'b1) begin
            bad++;
            $display("FAIL starve_regrant got=%b want=1", g10);
        end
        idle();
        run_cycle(e0, e1, d0, d1, mr, mw);
    endtask

    task automatic test_lock_burst();
        bit e0, e1;
        logic d0, d1, mr, mw;
        int n1, n0, g1_first4, cyc;
        logic c5_0, c5_1;
        n1 = 0; n0 = 0; g1_first4 = 0; cyc = 0;
        c5_0 = 0; c5_1 = 1;
        bus.m1_req = 1; bus.m1_wr = 1; bus.m1_lock = 1;
        bus.m1_addr = 32'h30; bus.m1_wdata = 32'hA0;
        while ((n1 < 6 || n0 < 3) && cyc < 40) begin
            cyc++;
            run_cycle(e0, e1, d0, d1, mr, mw);
            if (cyc <= 4 && d1) g1_first4++;
            if (cyc == 5) begin c5_0 = d0; c5_1 = d1; end
            if (e1) begin
                n1++;
                bus.m1_addr = bus.m1_addr + 1;
                bus.m1_wdata = bus.m1_wdata + 1;
                if (n1 == 6) bus.m1_req = 0;
            end
            if (e0) begin
                n0++;
                bus.m0_addr = bus.m0_addr + 1;
                if (n0 == 3) bus.m0_req = 0;
            end
            if (cyc == 1) begin
                bus.m0_req = 1; bus.m0_wr = 1;
                bus.m0_addr = 32'h8; bus.m0_wdata = 32'h55;
            end
        end
        total++;
        if (g1_first4 !== MAX_BURST) begin
            bad++;
            $display("FAIL burst_grants got=%0d want=%0d", g1_first4, MAX_BURST);
        end
        total++;
        if (c5_0 !== 1'b1 || c5_1 !== 1'b0) begin
            bad++;
            $display("FAIL cool_grant got=%b%b want=10", c5_0, c5_1);
        end
        total++;
        if (cyc >= 40) begin
            bad++;
            $display("FAIL burst_timeout got=%0d/%0d want=6/3", n1, n0);
        end
        idle();
        repeat (2) run_cycle(e0, e1, d0, d1, mr, mw);
    endtask

    task automatic test_rdwr_both();
        bit e0, e1;
        logic d0, d1, mr, mw;
        bus.m1_req = 1; bus.m1_rd = 1; bus.m1_wr = 1;
        bus.m1_addr = 32'h4000_0010; bus.m1_wdata = 32'h0000_00FF;
        run_cycle(e0, e1, d0, d1, mr, mw);
        total++;
        if (d1 !== 1'b1 || mw !== 1'b1 || mr !== 1'b0) begin
            bad++;
            $display("FAIL rdwr got=%b%b%b want=110", d1, mw, mr);
        end
        idle();
        total++;
        if (bus.m1_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL rdwr_rvalid got=%b want=0", bus.m1_rvalid);
        end
        run_cycle(e0, e1, d0, d1, mr, mw);
    endtask

    task automatic test_reset_lock();
        bit e0, e1;
        logic d0, d1, mr, mw;
        bus.m1_req = 1; bus.m1_rd = 1; bus.m1_lock = 1;
        bus.m1_addr = 32'h22;
        repeat (2) run_cycle(e0, e1, d0, d1, mr, mw);
        reset = 1;
        run_cycle(e0, e1, d0, d1, mr, mw);
        total++;
        if (bus.m1_rvalid !== 1'b0 || bus.m1_rdata !== 32'h0) begin
            bad++;
            $display("FAIL lock_reset got=%b/%h want=0/0", bus.m1_rvalid, bus.m1_rdata);
        end
        reset = 0;
        bus.m0_req = 1; bus.m0_rd = 1; bus.m0_addr = 32'h3;
        run_cycle(e0, e1, d0, d1, mr, mw);
        total++;
        if (d0 !== 1'b1 || d1 !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_gnt got=%b%b want=10", d0, d1);
        end
        idle();
        repeat (2) run_cycle(e0, e1, d0, d1, mr, mw);
    endtask

    task automatic test_random();
        bit e0, e1;
        logic d0, d1, mr, mw;
        e0 = 0; e1 = 0;
        for (int i = 0; i < 600; i++) begin
            if (!bus.m0_req || e0) begin
                bus.m0_req = ($urandom % 3) != 0;
                bus.m0_rd = $urandom % 2; bus.m0_wr = $urandom % 2;
                bus.m0_addr = $urandom_range(0, 63); bus.m0_wdata = $urandom;
            end else if ($urandom % 16 == 0) begin
                bus.m0_req = 0;
            end
            if (!bus.m1_req || e1) begin
                bus.m1_req = ($urandom % 4) != 0;
                bus.m1_rd = $urandom % 2; bus.m1_wr = $urandom % 2;
                bus.m1_addr = $urandom_range(0, 63); bus.m1_wdata = $urandom;
            end
            if ($urandom % 6 == 0) bus.m1_lock = ~bus.m1_lock;
            reset = ($urandom % 150) == 0;
            run_cycle(e0, e1, d0, d1, mr, mw);
        end
        reset = 0;
        idle();
        run_cycle(e0, e1, d0, d1, mr, mw);
    endtask

`ifdef MEM_BUS_ARB_STATS_EN
    task automatic test_stats();
        bit e0, e1;
        logic d0, d1, mr, mw;
        idle();
        reset = 1;
        run_cycle(e0, e1, d0, d1, mr, mw);
        reset = 0;
        bus.m0_req = 1; bus.m0_wr = 1;
        repeat (3) run_cycle(e0, e1, d0, d1, mr, mw);
        idle();
        bus.m1_req = 1; bus.m1_wr = 1;
        repeat (2) run_cycle(e0, e1, d0, d1, mr, mw);
        idle();
        total++;
        if (stat_gnt0 !== 16'd3 || stat_gnt1 !== 16'd2 || stat_starve !== 16'd0) begin
            bad++;
            $display("FAIL stats got=%0d/%0d/%0d want=3/2/0",
                     stat_gnt0, stat_gnt1, stat_starve);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = $urandom;
        md_mode = 0; md_starve = 0; md_burst = 0;
        md_rv0 = 0; md_rv1 = 0; md_rd0 = 0; md_rd1 = 0;
        idle();
        test_reset();
        test_both_read();
        test_starve();
        test_lock_burst();
        test_rdwr_both();
        test_reset_lock();
        test_random();
`ifdef MEM_BUS_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates the single data-memory port (DataMem: RAM plus LED/switch/digit/UART/timer registers) between two masters: the CPU MEM stage (master 0) and the UART program loader / DMA engine (master 1). Master 0 has fixed priority. Master 1 is guaranteed forward progress by a starvation counter and may hold the port for short locked bursts. The block sits between the MEM stage and DataMem, and drives DataMem's read/write/addr/wdata.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 8, consecutive denied cycles after which master 1 wins over master 0 (≥1)
- MAX_BURST, 4, maximum consecutive locked grants to master 1 (≥1)

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-high
- m0_req / m0_rd / m0_wr  in  1  CPU request, read, write
- m0_addr  in  ADDR_W  CPU address
- m0_wdata  in  DATA_W  CPU write data
- m0_gnt  out  1  CPU granted this cycle; the CPU stalls while m0_req & !m0_gnt
- m0_rdata  out  DATA_W  registered read data
- m0_rvalid  out  1  m0_rdata valid (1-cycle pulse)
- m1_req / m1_rd / m1_wr / m1_lock  in  1  loader request, read, write, burst lock
- m1_addr, m1_wdata, m1_gnt, m1_rdata, m1_rvalid: as for master 0
- mem_read / mem_write  out  1  to DataMem
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W
- mem_rdata  in  DATA_W  combinational read data from DataMem

## Operation
- States: S_ARB (normal), S_LOCK1 (master 1 owns the port), S_COOL (master 1 excluded for one cycle).
- S_ARB priority:
  1. m1_req & starve==STARVE_LIMIT → master 1.
  2. Else m0_req → master 0.
  3. Else m1_req → master 1.
- A master 1 grant in S_ARB with m1_lock=1 → S_LOCK1 with burst=1.
- S_LOCK1: master 1 granted while m1_req. burst increments per grant. Exit to S_ARB when m1_req=0 or m1_lock=0; the exiting cycle does not grant master 1. When the cycle's grant makes burst reach MAX_BURST, the next state is S_COOL. Master 0 waits throughout the lock.
- S_COOL: only master 0 may be granted. Always returns to S_ARB next cycle.
- starve counter: increments (saturating at STARVE_LIMIT) when m1_req & !m1_gnt. Clears on m1_gnt or when m1_req=0.
- Mux: the granted master's addr/wdata drive mem_*. mem_write = wr. mem_read = rd & !wr (write wins when both are set). When no grant is given, all mem_* = 0.
- A grant with rd=wr=0 consumes the cycle and produces no rvalid.
- Read return: on a granted read, mem_rdata is registered into that master's rdata, and rvalid pulses the next cycle. The other master's rdata holds its value.
- Reset (synchronous): state=S_ARB, starve=0, burst=0, all rdata=0, rvalid=0. Grants and mem_* are combinational and are 0 while reset=1. Reset in the middle of a lock abandons the burst. A read pending at reset produces no rvalid.

## Timing
- Grant: combinational, same cycle as the request. Memory access happens in the granted cycle.
- Read latency: rvalid exactly 1 cycle after the granted read.
- Throughput: one access per cycle, no bubbles, except the S_LOCK1 exit cycle (nothing granted to master 1) and S_COOL.
- Masters hold req/addr/wdata stable until they see gnt. Dropping req before grant is legal.
- Worst-case master 0 wait: MAX_BURST + 1 cycles. Worst-case master 1 wait with continuous CPU traffic: STARVE_LIMIT + 1 cycles.

## Configuration
- Macro: MEM_BUS_ARB_STATS_EN.
- Defined: adds outputs stat_gnt0, stat_gnt1 (16-bit saturating grant counters) and stat_starve (16-bit count of starvation-forced grants). All reset to 0.
- Undefined: these ports and counters are absent. Arbitration behaviour is identical.

## Structure
- Package mem_arb_pkg: state enum (S_ARB, S_LOCK1, S_COOL), master index constants (M_CPU=0, M_LDR=1), stats counter width.
- One sub-module: arb_stats (the counters), instantiated only under MEM_BUS_ARB_STATS_EN.

## Test plan
- Both masters request reads in the same cycle (addr 0x10 / 0x20, no starvation) → m0_gnt=1, m1_gnt=0, mem_addr=0x10. Next cycle m0_rvalid=1, m0_rdata=mem[0x10].
- Continuous m0 traffic, m1_req held high → m1 granted in cycle 9 (STARVE_LIMIT=8), starve cleared, m0 regranted in cycle 10.
- m1 locked burst of 6 writes, MAX_BURST=4, m0 requesting → 4 m1 grants, then S_COOL grants m0, then arbitration resumes.
- m1 sets rd and wr together, addr 0x40000010 (LED) → mem_write=1, mem_read=0, no rvalid.
- Reset asserted during S_LOCK1 with a read pending → next cycle state S_ARB, rvalid=0, counters 0. m0 is granted immediately after reset is released.
- With MEM_BUS_ARB_STATS_EN: 3 m0 grants and 2 m1 grants → stat_gnt0=3, stat_gnt1=2.
